// File: rtl/ghpi_bus_arbiter_if.sv
// Signal bundle between the imem/dmem masters, the arbiter and the shared memory bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
`timescale 1ns/1ps
interface ghpi_bus_arbiter_if;
    logic [31:0] imem_addr_i;
    logic        imem_valid_i;
    logic [31:0] imem_data_o;
    logic        imem_ack_o;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_data_i;
    logic [3:0]  dmem_sel_i;
    logic        dmem_we_i;
    logic        dmem_valid_i;
    logic [31:0] dmem_data_o;
    logic        dmem_ack_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic        bus_we_o;
    logic        bus_valid_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        timeout_o;

    modport slave (
        input  imem_addr_i, imem_valid_i,
        input  dmem_addr_i, dmem_data_i, dmem_sel_i, dmem_we_i, dmem_valid_i,
        input  bus_data_i, bus_ack_i,
        output imem_data_o, imem_ack_o, dmem_data_o, dmem_ack_o,
        output bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_valid_o, timeout_o
    );

    modport master (
        output imem_addr_i, imem_valid_i,
        output dmem_addr_i, dmem_data_i, dmem_sel_i, dmem_we_i, dmem_valid_i,
        output bus_data_i, bus_ack_i,
        input  imem_data_o, imem_ack_o, dmem_data_o, dmem_ack_o,
        input  bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_valid_o, timeout_o
    );
endinterface

// File: rtl/ghpi_bus_arbiter.sv
// Merges imem and dmem valid/ack masters onto one memory bus with a registered grant,
// round-robin or dmem-priority arbitration and an optional watchdog against a dead slave.
`timescale 1ns/1ps
module ghpi_bus_arbiter #(
    parameter int unsigned PRIORITY       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic               clk_i,
    input logic               rst_i,
    ghpi_bus_arbiter_if.slave bus_if
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    state_e state_q, state_d, arb;
    logic   last_d_q, last_d_d;  // most recent grant went to dmem
    logic   valid_raw, handshake, expire, complete, take_arb;

    always_comb begin
        arb = StIdle;
        if (bus_if.imem_valid_i && bus_if.dmem_valid_i) begin
            arb = (PRIORITY != 0 || !last_d_q) ? StGntD : StGntI;
        end else if (bus_if.imem_valid_i) begin
            arb = StGntI;
        end else if (bus_if.dmem_valid_i) begin
            arb = StGntD;
        end
    end

    always_comb begin
        bus_if.bus_addr_o = '0;
        bus_if.bus_data_o = '0;
        bus_if.bus_sel_o  = '0;
        bus_if.bus_we_o   = 1'b0;
        valid_raw         = 1'b0;
        unique case (state_q)
            StGntI: begin
                bus_if.bus_addr_o = bus_if.imem_addr_i;
                bus_if.bus_sel_o  = 4'b1111;
                valid_raw         = bus_if.imem_valid_i;
            end
            StGntD: begin
                bus_if.bus_addr_o = bus_if.dmem_addr_i;
                bus_if.bus_data_o = bus_if.dmem_data_i;
                bus_if.bus_sel_o  = bus_if.dmem_sel_i;
                bus_if.bus_we_o   = bus_if.dmem_we_i;
                valid_raw         = bus_if.dmem_valid_i;
            end
            default: ;
        endcase
    end

    assign bus_if.bus_valid_o = valid_raw & ~expire;
    assign handshake          = bus_if.bus_valid_o & bus_if.bus_ack_i;
    // A dropped request (abort) also ends the transfer, without any ack.
    assign complete           = (state_q != StIdle) && (handshake || !valid_raw || expire);
    assign take_arb           = (state_q == StIdle) || complete;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        if (take_arb) begin
            state_d = arb;
            if (arb != StIdle) begin
                last_d_d = (arb == StGntD);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

        logic [CntW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (take_arb) begin
                cnt_d = '0;
            end else if (!handshake) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // A real ack in the expiry cycle takes precedence over the forced completion.
        assign expire = (state_q != StIdle) && valid_raw && !bus_if.bus_ack_i &&
                        (cnt_q == CntLast);
    end else begin : g_no_wdog
        assign expire = 1'b0;
    end

    assign bus_if.timeout_o   = expire;
    assign bus_if.imem_ack_o  = (state_q == StGntI) && (handshake || expire);
    assign bus_if.dmem_ack_o  = (state_q == StGntD) && (handshake || expire);
    assign bus_if.imem_data_o = (state_q == StIdle || (state_q == StGntI && expire)) ?
                                '0 : bus_if.bus_data_i;
    assign bus_if.dmem_data_o = (state_q == StIdle || (state_q == StGntD && expire)) ?
                                '0 : bus_if.bus_data_i;

endmodule

// File: tb/tb_ghpi_bus_arbiter.sv
// Self-checking bench: instance 0 is round-robin with a 4-cycle watchdog, instance 1 is
// dmem-priority with no watchdog. The slave returns its address XOR Key as read data.
`timescale 1ns/1ps
module tb_ghpi_bus_arbiter;

    localparam logic [31:0] Key = 32'hA5A5_0000;
    localparam logic [31:0] IK  = 32'hA5A5_0100;  // read data for imem addr 0x100
    localparam logic [31:0] DK  = 32'h85A5_0004;  // read data for dmem addr 0x2000_0004

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ghpi_bus_arbiter_if rr_if ();
    ghpi_bus_arbiter_if pr_if ();

    ghpi_bus_arbiter #(.PRIORITY(0), .TIMEOUT_CYCLES(4)) u_rr (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus_if(rr_if.slave)
    );

    ghpi_bus_arbiter #(.PRIORITY(1), .TIMEOUT_CYCLES(0)) u_pr (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus_if(pr_if.slave)
    );

    logic        iv [2], dv [2], dwe [2], ack [2];
    logic [31:0] iaddr [2], daddr [2], ddata [2];
    logic [3:0]  dsel [2];
    logic        obv [2], oia [2], oda [2], oto [2], owe [2];
    logic [31:0] oid [2], odd [2], oaddr [2], obdata [2];
    logic [3:0]  osel [2];

    assign rr_if.imem_addr_i  = iaddr[0];
    assign rr_if.imem_valid_i = iv[0];
    assign rr_if.dmem_addr_i  = daddr[0];
    assign rr_if.dmem_data_i  = ddata[0];
    assign rr_if.dmem_sel_i   = dsel[0];
    assign rr_if.dmem_we_i    = dwe[0];
    assign rr_if.dmem_valid_i = dv[0];
    assign rr_if.bus_ack_i    = ack[0];
    assign rr_if.bus_data_i   = rr_if.bus_addr_o ^ Key;
    assign pr_if.imem_addr_i  = iaddr[1];
    assign pr_if.imem_valid_i = iv[1];
    assign pr_if.dmem_addr_i  = daddr[1];
    assign pr_if.dmem_data_i  = ddata[1];
    assign pr_if.dmem_sel_i   = dsel[1];
    assign pr_if.dmem_we_i    = dwe[1];
    assign pr_if.dmem_valid_i = dv[1];
    assign pr_if.bus_ack_i    = ack[1];
    assign pr_if.bus_data_i   = pr_if.bus_addr_o ^ Key;

    assign obv[0] = rr_if.bus_valid_o;  assign obv[1] = pr_if.bus_valid_o;
    assign oia[0] = rr_if.imem_ack_o;   assign oia[1] = pr_if.imem_ack_o;
    assign oda[0] = rr_if.dmem_ack_o;   assign oda[1] = pr_if.dmem_ack_o;
    assign oto[0] = rr_if.timeout_o;    assign oto[1] = pr_if.timeout_o;
    assign owe[0] = rr_if.bus_we_o;     assign owe[1] = pr_if.bus_we_o;
    assign oid[0] = rr_if.imem_data_o;  assign oid[1] = pr_if.imem_data_o;
    assign odd[0] = rr_if.dmem_data_o;  assign odd[1] = pr_if.dmem_data_o;
    assign oaddr[0] = rr_if.bus_addr_o; assign oaddr[1] = pr_if.bus_addr_o;
    assign obdata[0] = rr_if.bus_data_o; assign obdata[1] = pr_if.bus_data_o;
    assign osel[0] = rr_if.bus_sel_o;   assign osel[1] = pr_if.bus_sel_o;

    typedef struct {
        int          inst;
        logic        iv, dv, ack;
        logic        ebv, eia, eda, eto;
        logic [31:0] eid;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] iq [$];
    logic [31:0] dq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        for (int i = 0; i < 2; i++) begin
            iv[i]  = 1'b0;
            dv[i]  = 1'b0;
            ack[i] = 1'b0;
            dwe[i] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic ni, nd;
        rst_n = 1'b0;
        clr_inputs();
        for (int i = 0; i < 2; i++) begin
            iaddr[i] = 32'h0000_0100;
            daddr[i] = 32'h2000_0004;
            ddata[i] = '0;
            dsel[i]  = '0;
        end

        // inst iv dv ack | bv iack dack to | imem_data
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 32'h0});  // imem-only read, ack 2 cycles late
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, IK});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, IK});
        tbl.push_back('{0, 1, 0, 1, 1, 1, 0, 0, IK});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, IK});     // regranted, then aborted
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 32'h0});  // silent slave -> watchdog
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, IK});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, IK});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, IK});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 1, 32'h0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, IK});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 0, 32'h0});  // dmem priority under contention
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 0, DK});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 0, DK});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 0, DK});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 0, DK});
        tbl.push_back('{1, 1, 0, 1, 1, 1, 0, 0, IK});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, IK});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d bus_valid", i), 32'(obv[i]), 0);
            chk($sformatf("rst%0d imem_ack", i), 32'(oia[i]), 0);
            chk($sformatf("rst%0d dmem_ack", i), 32'(oda[i]), 0);
            chk($sformatf("rst%0d timeout", i), 32'(oto[i]), 0);
            chk($sformatf("rst%0d bus_we", i), 32'(owe[i]), 0);
            chk($sformatf("rst%0d bus_sel", i), 32'(osel[i]), 0);
            chk($sformatf("rst%0d bus_addr", i), oaddr[i], 0);
            chk($sformatf("rst%0d bus_data", i), obdata[i], 0);
            chk($sformatf("rst%0d imem_data", i), oid[i], 0);
            chk($sformatf("rst%0d dmem_data", i), odd[i], 0);
        end
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            int i;
            i = tbl[r].inst;
            clr_inputs();
            iv[i]  = tbl[r].iv;
            dv[i]  = tbl[r].dv;
            ack[i] = tbl[r].ack;
            #1;
            chk($sformatf("row%0d bus_valid", r), 32'(obv[i]), 32'(tbl[r].ebv));
            chk($sformatf("row%0d imem_ack", r), 32'(oia[i]), 32'(tbl[r].eia));
            chk($sformatf("row%0d dmem_ack", r), 32'(oda[i]), 32'(tbl[r].eda));
            chk($sformatf("row%0d timeout", r), 32'(oto[i]), 32'(tbl[r].eto));
            chk($sformatf("row%0d imem_data", r), oid[i], tbl[r].eid);
            tick();
        end

        // Round-robin alternation with a zero-wait slave, tracked through a scoreboard.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        iaddr[0] = 32'h0000_0100;
        daddr[0] = 32'h2000_0000;
        ddata[0] = 32'h1234_5678;
        dsel[0]  = 4'b0011;
        iq.push_back(iaddr[0] ^ Key);
        dq.push_back(daddr[0] ^ Key);
        for (int k = 0; k < 9; k++) begin
            iv[0]  = 1'b1;
            dv[0]  = 1'b1;
            ack[0] = 1'b1;
            #1;
            ni = 1'b0;
            nd = 1'b0;
            chk($sformatf("rr%0d bus_valid", k), 32'(obv[0]), 32'(k > 0));
            chk($sformatf("rr%0d imem_ack", k), 32'(oia[0]), 32'(k > 0 && k % 2 == 1));
            chk($sformatf("rr%0d dmem_ack", k), 32'(oda[0]), 32'(k > 0 && k % 2 == 0));
            if (k > 0) begin
                chk($sformatf("rr%0d bus_sel", k), 32'(osel[0]), (k % 2 == 1) ? 32'hF : 32'h3);
                chk($sformatf("rr%0d bus_data", k), obdata[0],
                    (k % 2 == 1) ? 32'h0 : 32'h1234_5678);
            end
            if (oia[0]) begin
                if (iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rr%0d imem ack with empty queue: got ack expected none", k);
                end else begin
                    chk($sformatf("rr%0d imem_data", k), oid[0], iq.pop_front());
                    ni = 1'b1;
                end
            end
            if (oda[0]) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rr%0d dmem ack with empty queue: got ack expected none", k);
                end else begin
                    chk($sformatf("rr%0d dmem_data", k), odd[0], dq.pop_front());
                    nd = 1'b1;
                end
            end
            tick();
            if (ni) begin
                iaddr[0] = iaddr[0] + 32'd4;
                iq.push_back(iaddr[0] ^ Key);
            end
            if (nd) begin
                daddr[0] = daddr[0] + 32'd4;
                dq.push_back(daddr[0] ^ Key);
            end
        end
        chk("rr imem outstanding", 32'(iq.size()), 1);
        chk("rr dmem outstanding", 32'(dq.size()), 1);
        clr_inputs();
        tick();
        tick();

        // dmem write passes through untouched.
        daddr[0] = 32'h2000_0004;
        ddata[0] = 32'h00AB_0000;
        dsel[0]  = 4'b0100;
        dwe[0]   = 1'b1;
        dv[0]    = 1'b1;
        #1;
        chk("wr idle bus_valid", 32'(obv[0]), 0);
        tick();
        chk("wr bus_valid", 32'(obv[0]), 1);
        chk("wr bus_addr", oaddr[0], 32'h2000_0004);
        chk("wr bus_data", obdata[0], 32'h00AB_0000);
        chk("wr bus_sel", 32'(osel[0]), 32'h4);
        chk("wr bus_we", 32'(owe[0]), 1);
        chk("wr wait dmem_ack", 32'(oda[0]), 0);
        ack[0] = 1'b1;
        #1;
        chk("wr dmem_ack", 32'(oda[0]), 1);
        chk("wr imem_ack", 32'(oia[0]), 0);
        chk("wr dmem_data", odd[0], DK);
        tick();
        clr_inputs();
        tick();
        tick();

        // Reset while dmem waits on the slave.
        dv[0] = 1'b1;
        tick();
        chk("rm bus_valid before", 32'(obv[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("rm bus_valid async", 32'(obv[0]), 0);
        chk("rm dmem_ack async", 32'(oda[0]), 0);
        iv[0]  = 1'b1;
        ack[0] = 1'b1;
        #1;
        chk("rm imem_ack held", 32'(oia[0]), 0);
        chk("rm dmem_ack held", 32'(oda[0]), 0);
        tick();
        chk("rm bus_valid edge", 32'(obv[0]), 0);
        rst_n = 1'b1;
        #1;
        chk("rm idle bus_valid", 32'(obv[0]), 0);
        tick();
        chk("rm first imem_ack", 32'(oia[0]), 1);
        chk("rm first dmem_ack", 32'(oda[0]), 0);
        tick();
        chk("rm second dmem_ack", 32'(oda[0]), 1);
        chk("rm second imem_ack", 32'(oia[0]), 0);
        clr_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
